// File: rtl/line_fill_mem_responder.sv
// Memory-side responder for the cache refill port: single-word writes and
// critical-word-first line-fill reads after a fixed access latency.
module line_fill_mem_responder #(
  parameter int LATENCY    = 5,
  parameter int LINE_WORDS = 4,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_req,
  input  logic        wr_req,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        ready,
  output logic        busy,
  output logic        protocol_err
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]         CNT_INIT  = CW'(LATENCY - 1);
  localparam logic [DEPTH_LOG2-1:0] LINE_MASK = DEPTH_LOG2'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT, BURST, DONE} state_t;

  logic [31:0] mem [2**DEPTH_LOG2];

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] beat_q, beat_d;
  logic [DEPTH_LOG2-1:0] widx_q, widx_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  wr_q, wr_d;
  logic                  perr_q, perr_d;
  logic [31:0]           rdata_q, rdata_d;

  logic                  wr_fire, rd_fire;
  logic [DEPTH_LOG2-1:0] widx_src, rd_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      beat_q  <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      widx_q  <= widx_d;
      wdata_q <= wdata_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
      rdata_q <= rdata_d;
    end
  end

  // Storage is not reset; a reset on the write edge itself drops the write.
  always_ff @(posedge clk) begin
    if (!reset && wr_fire) mem[widx_q] <= wdata_q;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    widx_d  = widx_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    perr_d  = 1'b0;
    unique case (state_q)
      IDLE: if (rd_req || wr_req) begin
        widx_d  = addr[DEPTH_LOG2+1:2];
        wdata_d = wdata;
        wr_d    = wr_req;
        perr_d  = rd_req && wr_req;
        cnt_d   = CNT_INIT;
        beat_d  = '0;
        // With a one-cycle latency beat 0 must already be on the bus in cycle 1.
        state_d = (!wr_req && LATENCY == 1) ? BURST : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (wr_q) begin
          if (cnt_q == '0) state_d = DONE;
        end else if (cnt_q <= CW'(1)) begin
          state_d = BURST;
          beat_d  = '0;
        end
      end
      BURST: begin
        if (beat_q == LINE_MASK) state_d = DONE;
        else beat_d = beat_q + DEPTH_LOG2'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array read one cycle ahead of the beat so the registered data lines up.
  always_comb begin
    widx_src = (state_q == IDLE) ? addr[DEPTH_LOG2+1:2] : widx_q;
    rd_idx   = (widx_src & ~LINE_MASK) | ((widx_src + beat_d) & LINE_MASK);
    rd_fire  = (state_d == BURST);
    wr_fire  = (state_q == WAIT) && wr_q && (cnt_q == '0);
    rdata_d  = rd_fire ? mem[rd_idx] : rdata_q;
  end

  always_comb begin
    rdata        = rdata_q;
    rdata_valid  = (state_q == BURST);
    ready        = wr_fire || ((state_q == BURST) && (beat_q == LINE_MASK));
    busy         = (state_q != IDLE);
    protocol_err = perr_q;
  end
endmodule

// File: tb/tb_line_fill_mem_responder.sv
// Bench for line_fill_mem_responder: table of transactions plus reset corner
// sequences; read beats are checked against a queue of expected words.
module tb_line_fill_mem_responder;
  localparam int LAT = 5;
  localparam int LW  = 4;

  logic        clk = 1'b0;
  logic        reset, rd_req, wr_req;
  logic [31:0] addr, wdata, rdata;
  logic        rdata_valid, ready, busy, protocol_err;

  line_fill_mem_responder #(.LATENCY(LAT), .LINE_WORDS(LW), .DEPTH_LOG2(12)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid), .ready(ready),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          rdy_cyc;
    bit          perr;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] model [0:4095];
  logic [31:0] expq [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rdata_valid === 1'b1) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL beat_unexpected: got %h expected no beat", rdata);
      end else chk("beat_data", rdata, expq.pop_front());
    end
  end

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'hFFF);
  endfunction

  function automatic vec_t mk(input bit rd, input bit wr, input logic [31:0] a,
                              input logic [31:0] d, input int r, input bit p);
    vec_t v;
    v.rd = rd; v.wr = wr; v.a = a; v.d = d; v.rdy_cyc = r; v.perr = p;
    return v;
  endfunction

  task automatic push_line(input logic [31:0] a);
    int w;
    w = widx(a);
    for (int k = 0; k < LW; k++) expq.push_back(model[(w & ~(LW-1)) | ((w + k) & (LW-1))]);
  endtask

  task automatic txn(input vec_t v, input bit hold);
    logic [31:0] last;
    last = '0;
    @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    rd_req = v.rd; wr_req = v.wr; addr = v.a; wdata = v.d;
    if (v.wr) model[widx(v.a)] = v.d;
    else begin
      push_line(v.a);
      last = expq[expq.size()-1];
    end
    for (int c = 1; c <= v.rdy_cyc + 1; c++) begin
      @(negedge clk);
      if (!hold) begin
        rd_req = 1'b0; wr_req = 1'b0; addr = $urandom; wdata = $urandom;
      end
      chk("ready", {31'b0, ready}, {31'b0, c == v.rdy_cyc});
      chk("busy", {31'b0, busy}, 32'd1);
      chk("perr", {31'b0, protocol_err}, {31'b0, v.perr && c == 1});
      chk("valid", {31'b0, rdata_valid}, {31'b0, !v.wr && c >= LAT && c <= v.rdy_cyc});
      if (!v.wr && c == v.rdy_cyc + 1) chk("rdata_hold", rdata, last);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_valid"}, {31'b0, rdata_valid}, 32'd0);
    chk({tag, "_ready"}, {31'b0, ready}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_perr"}, {31'b0, protocol_err}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [$];
    vec_t rd40;
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset = 1'b0;

    tbl.push_back(mk(0, 1, 32'h40, 32'hDEADBEEF, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h40, 32'd1, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h44, 32'd2, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h48, 32'd3, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h4C, 32'd4, LAT, 0));
    tbl.push_back(mk(1, 0, 32'h48, 32'd0, LAT+LW-1, 0));
    tbl.push_back(mk(1, 1, 32'h10, 32'h55, LAT, 1));
    tbl.push_back(mk(0, 1, 32'h14, 32'h66, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h18, 32'h77, LAT, 0));
    tbl.push_back(mk(0, 1, 32'h1C, 32'h88, LAT, 0));
    tbl.push_back(mk(1, 0, 32'h1F, 32'd0, LAT+LW-1, 0));
    tbl.push_back(mk(0, 1, 32'h4000_4044, 32'hA5A5, LAT, 0));
    tbl.push_back(mk(1, 0, 32'h44, 32'd0, LAT+LW-1, 0));
    for (int i = 0; i < tbl.size(); i++) txn(tbl[i], 1'b0);

    // held read request: DONE must not retrigger, IDLE must
    rd40 = mk(1, 0, 32'h40, 32'd0, LAT+LW-1, 0);
    txn(rd40, 1'b1);
    txn(rd40, 1'b0);

    // reset in cycle 3 of a write discards it
    txn(mk(0, 1, 32'h80, 32'h0, LAT, 0), 1'b0);
    txn(mk(0, 1, 32'h84, 32'h11, LAT, 0), 1'b0);
    txn(mk(0, 1, 32'h88, 32'h22, LAT, 0), 1'b0);
    txn(mk(0, 1, 32'h8C, 32'h33, LAT, 0), 1'b0);
    @(negedge clk);
    wr_req = 1'b1; addr = 32'h80; wdata = 32'h1234;
    @(posedge clk);
    repeat (3) @(negedge clk);
    reset = 1'b1; wr_req = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_wr");
    reset = 1'b0;
    txn(mk(1, 0, 32'h80, 32'd0, LAT+LW-1, 0), 1'b0);

    // reset during beat 2 of a read
    @(negedge clk);
    rd_req = 1'b1; addr = 32'h40;
    push_line(32'h40);
    @(posedge clk);
    repeat (LAT + 2) @(negedge clk);
    reset = 1'b1; rd_req = 1'b0;
    @(negedge clk);
    chk_idle_outputs("rst_rd");
    reset = 1'b0;
    #1;
    chk("beats_left", expq.size(), 32'd1);
    expq.delete();
    txn(mk(1, 0, 32'h48, 32'd0, LAT+LW-1, 0), 1'b0);

    repeat (2) @(negedge clk);
    chk("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
